famicom_cpu_bus_initiator: RTL and testbench

//  Console-side initiator for the cartridge CPU bus. Generates the free-running M2 clock, /ROMSEL, R/W,
//  A[14:0] and the D[7:0] drive/sample timing from a simple request/response handshake.

---
 rtl/famicom_cpu_bus_initiator_if.sv | 20 ++
 rtl/famicom_cpu_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_famicom_cpu_bus_initiator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/famicom_cpu_bus_initiator_if.sv
// Request/response handshake between a requester and the Famicom CPU bus initiator.
interface famicom_cpu_bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/famicom_cpu_bus_initiator.sv
// Console-side Famicom cartridge CPU bus initiator: free-running M2, /ROMSEL, R/W, A[14:0], D timing.
// Define CPU_BUS_IRQ_SYNC_EN to add the irq_n input and its two-flop synchroniser.
module famicom_cpu_bus_initiator #(
    parameter int unsigned LOW_CYCLES  = 3,
    parameter int unsigned HIGH_CYCLES = 3,
    parameter logic [15:0] IDLE_ADDR   = 16'h0000
) (
    input  logic                              clk,
    input  logic                              rst,
    famicom_cpu_bus_initiator_if.slave        bus,
    output logic                              m2,
    output logic                              romsel,
    output logic                              cpu_rw,
    output logic [14:0]                       cpu_addr,
    output logic [7:0]                        cpu_data_out,
    output logic                              cpu_data_oe,
    input  logic [7:0]                        cpu_data_in,
    output logic [15:0]                       bus_cycles,
`ifdef CPU_BUS_IRQ_SYNC_EN
    input  logic                              irq_n,
`endif
    output logic                              irq_pending
);

    localparam int unsigned P  = LOW_CYCLES + HIGH_CYCLES;
    localparam int unsigned KW = $clog2(P);

    localparam logic [KW-1:0] K_LAST = KW'(P - 1);
    localparam logic [KW-1:0] K_HIGH = KW'(LOW_CYCLES);
    localparam logic [KW-1:0] K_OE   = KW'(LOW_CYCLES + 1);

    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic          accept;

    // attributes of the bus cycle currently in flight
    logic          a15_q;
    logic          req_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;

    logic          m2_d;
    logic          romsel_d;
    logic          rw_d;
    logic [14:0]   addr_d;
    logic [7:0]    dout_d;
    logic          oe_d;
    logic          a15_d;
    logic          req_d;
    logic          rsp_valid_d;
    logic [7:0]    rsp_rdata_d;
    logic [15:0]   cycles_d;

    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.req_ready  = (k == '0) && !rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;

    // phase counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else begin
            k <= k_next;
        end
    end

    // free-running phase advance, wraps after the M2-high half
    always_comb begin
        k_next = k + KW'(1);
        if (k == K_LAST) begin
            k_next = '0;
        end
    end

    // next values of the bus pins and handshake outputs, all taken on the following edge
    always_comb begin
        addr_d      = cpu_addr;
        rw_d        = cpu_rw;
        dout_d      = cpu_data_out;
        a15_d       = a15_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        cycles_d    = bus_cycles;

        if (k == '0) begin
            if (accept) begin
                addr_d = bus.req_addr[14:0];
                a15_d  = bus.req_addr[15];
                rw_d   = ~bus.req_write;
                dout_d = bus.req_write ? bus.req_wdata : 8'h00;
                req_d  = 1'b1;
            end else begin
                addr_d = IDLE_ADDR[14:0];
                a15_d  = IDLE_ADDR[15];
                rw_d   = 1'b1;
                dout_d = 8'h00;
                req_d  = 1'b0;
            end
        end

        m2_d     = (k_next >= K_HIGH);
        romsel_d = ~(m2_d & a15_d);
        // write data stays driven through the 1-clk hold after M2 falls
        oe_d     = ~rw_d & ((k_next >= K_OE) | (k_next == '0));

        if (k == K_LAST) begin
            rsp_valid_d = req_q;
            if (req_q) begin
                rsp_rdata_d = cpu_rw ? cpu_data_in : 8'h00;
            end
            cycles_d = bus_cycles + 16'd1;
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2           <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw       <= 1'b1;
            cpu_addr     <= IDLE_ADDR[14:0];
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            a15_q        <= IDLE_ADDR[15];
            req_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            bus_cycles   <= 16'h0000;
        end else begin
            m2           <= m2_d;
            romsel       <= romsel_d;
            cpu_rw       <= rw_d;
            cpu_addr     <= addr_d;
            cpu_data_out <= dout_d;
            cpu_data_oe  <= oe_d;
            a15_q        <= a15_d;
            req_q        <= req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            bus_cycles   <= cycles_d;
        end
    end

`ifdef CPU_BUS_IRQ_SYNC_EN
    logic [1:0] irq_sync;

    // two-flop synchroniser for the asynchronous cartridge IRQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync <= 2'b11;
        end else begin
            irq_sync <= {irq_sync[0], irq_n};
        end
    end

    assign irq_pending = ~irq_sync[1];
`else
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_famicom_cpu_bus_initiator.sv
// Randomised scoreboard bench for famicom_cpu_bus_initiator against a phase-level bus model.
module tb_famicom_cpu_bus_initiator;

    localparam int unsigned LOW  = 3;
    localparam int unsigned HIGH = 3;
    localparam int unsigned P    = LOW + HIGH;
    localparam logic [15:0] IDLE = 16'h0000;

    typedef struct packed {
        logic        a15;
        logic [14:0] addr;
        logic        wr;
        logic [7:0]  wd;
    } cyc_t;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m2, romsel, cpu_rw, cpu_data_oe, irq_pending;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in = 8'h00;
    logic [15:0] bus_cycles;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned clk_cnt     = 0;
    rsp_t        exp_q[$];

    famicom_cpu_bus_initiator_if bus();

`ifdef CPU_BUS_IRQ_SYNC_EN
    logic       irq_n = 1'b1;
    logic [1:0] irq_hist;
`endif

    famicom_cpu_bus_initiator #(
        .LOW_CYCLES (LOW),
        .HIGH_CYCLES(HIGH),
        .IDLE_ADDR  (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .m2          (m2),
        .romsel      (romsel),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_data_oe (cpu_data_oe),
        .cpu_data_in (cpu_data_in),
        .bus_cycles  (bus_cycles),
`ifdef CPU_BUS_IRQ_SYNC_EN
        .irq_n       (irq_n),
`endif
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    // cartridge contents seen by reads, with a recognisable byte at $8000
    function automatic logic [7:0] mem(input logic [15:0] a);
        if (a == 16'h8000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef CPU_BUS_IRQ_SYNC_EN
    // irq_n as it was two edges ago
    always @(posedge clk or posedge rst) begin
        if (rst) irq_hist <= 2'b11;
        else     irq_hist <= {irq_hist[0], irq_n};
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
        end
    end
`endif

    // bus model: expected pin values per clk phase, plus the cartridge driving D
    initial begin : model
        int   n;
        int   ph;
        cyc_t cur;
        cyc_t idle;
        logic exp_m2, exp_oe, exp_irq;
        idle = '{a15: IDLE[15], addr: IDLE[14:0], wr: 1'b0, wd: 8'h00};
        cur  = idle;
        n    = 0;
        forever begin
            @(negedge clk);
`ifdef CPU_BUS_IRQ_SYNC_EN
            exp_irq = ~irq_hist[1];
`else
            exp_irq = 1'b0;
`endif
            if (rst) begin
                n   = 0;
                cur = idle;
                exp_q.delete();
                chk("rst_m2", 32'(m2), 32'd0);
                chk("rst_romsel", 32'(romsel), 32'd1);
                chk("rst_rw", 32'(cpu_rw), 32'd1);
                chk("rst_addr", 32'(cpu_addr), 32'(IDLE[14:0]));
                chk("rst_oe", 32'(cpu_data_oe), 32'd0);
                chk("rst_dout", 32'(cpu_data_out), 32'd0);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
                chk("rst_bus_cycles", 32'(bus_cycles), 32'd0);
                chk("rst_ready", 32'(bus.req_ready), 32'd0);
                chk("rst_irq", 32'(irq_pending), 32'd0);
                cpu_data_in = 8'($urandom);
                continue;
            end
            ph     = n % P;
            exp_m2 = (ph >= LOW);
            exp_oe = (ph == 0) ? cur.wr : (cur.wr && ph >= LOW + 1);
            chk("m2", 32'(m2), 32'(exp_m2));
            chk("romsel", 32'(romsel), 32'(!(exp_m2 && cur.a15)));
            chk("ready", 32'(bus.req_ready), 32'(ph == 0));
            chk("cpu_addr", 32'(cpu_addr), 32'(cur.addr));
            chk("cpu_rw", 32'(cpu_rw), 32'(!cur.wr));
            chk("data_oe", 32'(cpu_data_oe), 32'(exp_oe));
            chk("data_out", 32'(cpu_data_out), 32'(cur.wr ? cur.wd : 8'h00));
            chk("bus_cycles", 32'(bus_cycles), 32'(16'(n / P)));
            chk("irq_pending", 32'(irq_pending), 32'(exp_irq));
            if (ph == 0) begin
                if (bus.req_valid) begin
                    cur = '{a15: bus.req_addr[15], addr: bus.req_addr[14:0],
                            wr: bus.req_write, wd: bus.req_wdata};
                    exp_q.push_back('{due: clk_cnt + P,
                                      data: bus.req_write ? 8'h00 : mem(bus.req_addr)});
                end else begin
                    cur = idle;
                end
            end
            // valid read data only in the last M2-high clk, noise otherwise
            if (ph == P - 1 && cpu_rw && !cpu_data_oe)
                cpu_data_in = mem({~romsel, cpu_addr});
            else
                cpu_data_in = 8'($urandom);
            n++;
        end
    end

    // response monitor
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
                    chk("rsp_latency", clk_cnt, e.due);
                end
            end else if (exp_q.size() > 0 && clk_cnt > exp_q[0].due) begin
                chk("rsp_missing", 32'(bus.rsp_valid), 32'd1);
                e = exp_q.pop_front();
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic ok;
        ok            = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int c = 0; c < 2 * P && !ok; c++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk); #2;
        end
        chk("accept", 32'(ok), 32'd1);
        bus.req_valid = 1'b0;
    endtask

    initial begin : driver
        int gap;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        repeat (24) @(posedge clk);
        #1 chk("idle_24clk_cycles", 32'(bus_cycles), 32'd4);
        #1;

        issue(1'b0, 16'h8000, 8'h00);
        repeat (4) @(posedge clk); #2;
        issue(1'b1, 16'h5000, 8'h3C);
        repeat (3) @(posedge clk); #2;
        issue(1'b0, 16'hFFFC, 8'h00);
        issue(1'b1, 16'h8001, 8'h06);
        repeat (2 * P) @(posedge clk); #2;

        // reset in the middle of a write's M2-high phase
        issue(1'b1, 16'h6000, 8'h77);
        repeat (3) @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_m2", 32'(m2), 32'd0);
        chk("async_rst_oe", 32'(cpu_data_oe), 32'd0);
        chk("async_rst_rw", 32'(cpu_rw), 32'd1);
        chk("async_rst_cycles", 32'(bus_cycles), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #2;
            end
            issue(1'($urandom), 16'($urandom), 8'($urandom));
        end

        repeat (3 * P) @(posedge clk);
        #1 chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
